chu_vga_fade_core: RTL and testbench
====================================

# chu_vga_fade_core

Frame-synchronous fade-to-colour stage for the video daisy chain, built for a user slot (`V5_USER5` position, between the rgb-to-gray stage and the next user slot). It blends the incoming pixel stream with a programmable fade colour using a 0..16 alpha level. A frame-counting state machine steps the alpha only at frame boundaries, so fade-out and fade-in run autonomously after one start write.

## Interface
- `CD`, 12, colour depth; must be a multiple of 3; channel width `CW = CD/3`.
- `clk` input 1: system clock.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `x` input 11: current pixel column from the frame counter.
- `y` input 11: current pixel row from the frame counter.
- `cs` input 1: slot chip select.
- `write` input 1: slot write strobe; a register write occurs when `cs && write`.
- `addr` input 14: slot register address; only `addr[1:0]` is decoded.
- `wr_data` input 32: write data.
- `si_rgb` input CD: upstream pixel.
- `so_rgb` output CD: downstream pixel.

## Operation
- Registers (write-only, reset value 0):
  - addr 0 `ctrl`: bit0 `en`; bit1 `dir` (0 = fade out toward colour, 1 = fade in from colour); bit2 `start` (strobe, not stored).
  - addr 1 `color[CD-1:0]`.
  - addr 2 `period[7:0]`, in frames per alpha step; a value of 0 is treated as 1.
  - addr 3 is reserved; writes to it are ignored.
- Frame boundary tick `fb`:
  - `y_prev` register, reset value 0.
  - `fb = (y == 0) && (y_prev != 0)`.
  - `y_prev` updates every clock.
- `alpha` is 5 bits, range 0..16; `frame_cnt` is 8 bits.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: `alpha = 0`, `frame_cnt = 0`. A start write with `en = 1` goes to RUN and loads `alpha = dir ? 16 : 0` and `frame_cnt = 0`.
  - RUN: on `fb`:
    - If `frame_cnt == max(period,1) - 1`: clear `frame_cnt` and step `alpha` (+1 if `dir = 0`, -1 if `dir = 1`).
    - Otherwise increment `frame_cnt`.
    - When the stepped alpha reaches its terminal value (16 for `dir = 0`, 0 for `dir = 1`), go to HOLD.
  - HOLD: `alpha` is frozen. A start write goes back to RUN and reloads as in IDLE.
  - Any write of `ctrl` with `en = 0` goes to IDLE from any state.
- Datapath:
  - If `en = 0` or state is IDLE: `so_rgb = si_rgb`.
  - Otherwise, per channel: `out = (si*(16-alpha) + col*alpha) >> 4`, using a 9-bit intermediate for CW = 4.
  - `alpha = 16` gives exactly `color`; `alpha = 0` gives exactly `si_rgb`.
- Boundary conditions:
  - A start write in the same cycle as `fb`: the start wins and `fb` is ignored for that cycle.
  - A `period` write during RUN takes effect at the next `fb` comparison. If `frame_cnt >= new period - 1`, the step happens at that `fb`.
  - A `dir` write without start does not change the running fade. `dir` is sampled only at start and used for the step direction from then on.
  - The first frame after reset produces no `fb`, because `y_prev` starts at 0.

## Timing
- Datapath is combinational, `si_rgb` to `so_rgb`, with zero latency. This preserves daisy-chain alignment with the delayed `frame_start`.
- Register writes take effect on the clock edge following `cs && write`.
- State, alpha and counter updates are registered: they change one edge after `fb` or the start write.
- `alpha` changes only at the `fb` cycle (x = 0, y = 0), so no frame shows two alpha values.
- `x` and `y` may hold for several cycles while upstream stalls. Because `fb` is edge-detected on `y`, it fires exactly once per frame.
- `reset_n` low at any time sets state IDLE and clears all registers, `alpha`, `frame_cnt` and `y_prev` asynchronously. `so_rgb` then equals `si_rgb`.

## Configuration
- `FADE_ROUND_EN` defined: add 8 before `>> 4` in the blend (round to nearest).
- `FADE_ROUND_EN` not defined: truncate.
- Endpoints are exact in both modes (alpha 0 and alpha 16).

## Test plan
- Reset, then `si_rgb = 12'h5A3` with `en = 0` -> `so_rgb = 12'h5A3` in every cycle.
- `color = 12'h000`, `period = 1`, `dir = 0`, start -> alpha increments once per frame, reaching 16 and HOLD after 16 frames, with `so_rgb = 12'h000` from then on.
- `si_rgb = 12'hF00`, `color = 12'h000`, alpha held at 8 -> `so_rgb = 12'h700` without `FADE_ROUND_EN`, `12'h800` with it.
- `period = 0` vs `period = 1`: identical step timing. `period = 3`: alpha changes at every third `fb` only.
- Start write in the `fb` cycle during RUN at alpha 9 -> alpha reloads to 0 (`dir = 0`) and `frame_cnt = 0`, with no step that frame.
- `reset_n` asserted mid-RUN at alpha 5, then released -> IDLE with alpha 0 and pass-through, and no `fb` on the first frame after release.

Source files
------------

// File: rtl/chu_vga_fade_core.sv
// Frame-synchronous fade-to-colour stage: blends the pixel stream with a programmable colour.
// Optional build macro FADE_ROUND_EN selects round-to-nearest blending instead of truncation.
module chu_vga_fade_core #(
    parameter int CD = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    localparam int CW = CD / 3;
    localparam int IW = CW + 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic          en_q, en_d;
    logic          dir_q, dir_d;
    logic [CD-1:0] color_q, color_d;
    logic [7:0]    period_q, period_d;
    logic [4:0]    alpha_q, alpha_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [10:0]   y_prev_q, y_prev_d;

    logic       wr_en;
    logic       ctrl_wr;
    logic       start_wr;
    logic       stop_wr;
    logic       fb;
    logic [7:0] step_at;
    logic [4:0] alpha_step;

    // Column position and upper address/data bits carry no meaning for this slot.
    logic unused_ok;
    assign unused_ok = &{1'b0, x, addr[13:2], wr_data[31:CD]};

    assign wr_en    = cs && write;
    assign ctrl_wr  = wr_en && (addr[1:0] == 2'd0);
    assign start_wr = ctrl_wr && wr_data[0] && wr_data[2];
    assign stop_wr  = ctrl_wr && !wr_data[0];
    assign fb       = (y == 11'd0) && (y_prev_q != 11'd0);
    assign step_at  = (period_q == 8'd0) ? 8'd0 : period_q - 8'd1;

    // NOTE: every output of this block is assigned a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        dir_d       = dir_q;
        color_d     = color_q;
        period_d    = period_q;
        alpha_d     = alpha_q;
        frame_cnt_d = frame_cnt_q;
        y_prev_d    = y;
        alpha_step  = dir_q ? alpha_q - 5'd1 : alpha_q + 5'd1;

        if (ctrl_wr) en_d = wr_data[0];
        if (wr_en && addr[1:0] == 2'd1) color_d = wr_data[CD-1:0];
        if (wr_en && addr[1:0] == 2'd2) period_d = wr_data[7:0];

        if (stop_wr) begin
            state_d     = IDLE;
            alpha_d     = 5'd0;
            frame_cnt_d = 8'd0;
        end else if (start_wr) begin
            // Direction is captured only here; later dir writes leave the fade alone.
            state_d     = RUN;
            dir_d       = wr_data[1];
            alpha_d     = wr_data[1] ? 5'd16 : 5'd0;
            frame_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    alpha_d     = 5'd0;
                    frame_cnt_d = 8'd0;
                end
                RUN: begin
                    if (fb) begin
                        if (frame_cnt_q >= step_at) begin
                            frame_cnt_d = 8'd0;
                            alpha_d     = alpha_step;
                            if (alpha_step == (dir_q ? 5'd0 : 5'd16)) state_d = HOLD;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                HOLD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            dir_q       <= 1'b0;
            color_q     <= '0;
            period_q    <= 8'd0;
            alpha_q     <= 5'd0;
            frame_cnt_q <= 8'd0;
            y_prev_q    <= 11'd0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            dir_q       <= dir_d;
            color_q     <= color_d;
            period_q    <= period_d;
            alpha_q     <= alpha_d;
            frame_cnt_q <= frame_cnt_d;
            y_prev_q    <= y_prev_d;
        end
    end

    // Zero-latency blend keeps this stage aligned with the delayed frame_start of the chain.
    always_comb begin
        logic [IW-1:0] acc;
        logic [4:0]    inv;
        so_rgb = si_rgb;
        inv    = 5'd16 - alpha_q;
        acc    = '0;
        if (en_q && state_q != IDLE) begin
            for (int c = 0; c < 3; c++) begin
                acc = {5'd0, si_rgb[c*CW +: CW]} * {{CW{1'b0}}, inv}
                    + {5'd0, color_q[c*CW +: CW]} * {{CW{1'b0}}, alpha_q};
`ifdef FADE_ROUND_EN
                acc = acc + IW'(8);
`endif
                so_rgb[c*CW +: CW] = CW'(acc >> 4);
            end
        end
    end

endmodule

// File: tb/tb_chu_vga_fade_core.sv
// Self-checking bench for chu_vga_fade_core: scoreboard of expected pixels per sampled cycle.
module tb_chu_vga_fade_core;

    localparam int CD = 12;

    logic          clk;
    logic          reset_n;
    logic [10:0]   x;
    logic [10:0]   y;
    logic          cs;
    logic          write;
    logic [13:0]   addr;
    logic [31:0]   wr_data;
    logic [CD-1:0] si_rgb;
    logic [CD-1:0] so_rgb;

    chu_vga_fade_core #(.CD(CD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (x),
        .y       (y),
        .cs      (cs),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .si_rgb  (si_rgb),
        .so_rgb  (so_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference blend straight from the channel formula.
    function automatic logic [11:0] blend(input logic [11:0] si, input logic [11:0] col, input int a);
        logic [11:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            int s, k, v;
            s = int'(si[c*4 +: 4]);
            k = int'(col[c*4 +: 4]);
            v = s * (16 - a) + k * a;
`ifdef FADE_ROUND_EN
            v = v + 8;
`endif
            r[c*4 +: 4] = 4'(v / 16);
        end
        return r;
    endfunction

    // Drive a pixel, queue its expectation, compare on the falling edge.
    task automatic px(input string tag, input logic [11:0] si, input logic [11:0] exp);
        exp_t e;
        si_rgb = si;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, so_rgb, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        cs      = 1'b0;
        write   = 1'b0;
    endtask

    // One frame: y held non-zero (stalled) then held at zero, giving a single fb.
    task automatic frame();
        y = 11'd100;
        x = 11'd37;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        y = 11'd0;
        x = 11'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int a;
        reset_n = 1'b0;
        x = '0; y = '0; cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        si_rgb = 12'h5A3;
        repeat (2) @(posedge clk);
        #1;
        px("rst_pass", 12'h5A3, 12'h5A3);
        reset_n = 1'b1;
        px("en0_pass0", 12'h5A3, 12'h5A3);
        frame();
        px("en0_pass1", 12'h5A3, 12'h5A3);

        // Fade out to black, one step per frame, then hold.
        wr(14'd1, 32'h0);
        wr(14'd2, 32'd1);
        wr(14'd0, 32'h5);
        px("fo_a0", 12'hFFF, blend(12'hFFF, 12'h000, 0));
        for (int k = 1; k <= 16; k++) begin
            frame();
            px($sformatf("fo_a%0d", k), 12'hFFF, blend(12'hFFF, 12'h000, k));
        end
        frame();
        frame();
        px("hold_fff", 12'hFFF, 12'h000);
        px("hold_5a3", 12'h5A3, 12'h000);

        // Reserved address ignored; fade in from white (dir sampled at start).
        wr(14'd1, 32'hFFF);
        wr(14'd3, 32'h0000_0F00);
        wr(14'd0, 32'h7);
        a = 16;
        px("fi_a16", 12'h000, blend(12'h000, 12'hFFF, a));
        for (int k = 0; k < 2; k++) begin
            frame();
            a--;
            px($sformatf("fi_a%0d", a), 12'h000, blend(12'h000, 12'hFFF, a));
        end
        wr(14'd0, 32'h1);
        frame();
        a--;
        px("dir_nostart", 12'h000, blend(12'h000, 12'hFFF, a));

        // period 0 behaves as 1; mid-scale red check at alpha 8.
        wr(14'd1, 32'h0);
        wr(14'd2, 32'd0);
        wr(14'd0, 32'h5);
        for (int k = 1; k <= 8; k++) begin
            frame();
            px($sformatf("p0_a%0d", k), 12'hFFF, blend(12'hFFF, 12'h000, k));
        end
`ifdef FADE_ROUND_EN
        px("a8_red", 12'hF00, 12'h800);
`else
        px("a8_red", 12'hF00, 12'h700);
`endif

        // Start write coinciding with fb at alpha 9: reload wins, no step.
        wr(14'd2, 32'd1);
        frame();
        px("pre_fb_a9", 12'hFFF, blend(12'hFFF, 12'h000, 9));
        y = 11'd100;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        y = 11'd0;
        cs = 1'b1; write = 1'b1; addr = 14'd0; wr_data = 32'h5;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
        px("fbstart_a0", 12'hFFF, 12'hFFF);
        px("fbstart_a0b", 12'hFFF, 12'hFFF);
        frame();
        px("fbstart_a1", 12'hFFF, blend(12'hFFF, 12'h000, 1));

        // period 3: alpha steps on every third fb only.
        wr(14'd2, 32'd3);
        wr(14'd0, 32'h5);
        for (int f = 1; f <= 7; f++) begin
            frame();
            px($sformatf("p3_f%0d", f), 12'hFFF, blend(12'hFFF, 12'h000, f / 3));
        end
        wr(14'd1, 32'h3C9);
        px("col_mix", 12'h5A3, blend(12'h5A3, 12'h3C9, 2));

        // en = 0 returns to pass-through.
        wr(14'd0, 32'h0);
        px("stop_pass0", 12'h5A3, 12'h5A3);
        frame();
        px("stop_pass1", 12'h5A3, 12'h5A3);

        // Asynchronous reset mid-run at alpha 5.
        wr(14'd1, 32'h0);
        wr(14'd2, 32'd1);
        wr(14'd0, 32'h5);
        for (int k = 0; k < 5; k++) frame();
        px("mid_a5", 12'hFFF, blend(12'hFFF, 12'h000, 5));
        y = 11'd100;
        @(posedge clk);
        #1;
        y = 11'd0;
        #2;
        reset_n = 1'b0;
        px("rst_mid", 12'hFFF, 12'hFFF);
        reset_n = 1'b1;
        px("post_rst_pass", 12'hFFF, 12'hFFF);
        wr(14'd0, 32'h5);
        px("post_rst_a0", 12'hFFF, 12'hFFF);
        px("post_rst_nofb", 12'hFFF, 12'hFFF);
        frame();
        px("post_rst_a1", 12'hFFF, blend(12'hFFF, 12'h000, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
